control_fsm_gen: RTL and testbench

CONTROL_FSM_GEN -- requirements
Module: control_fsm_gen

---
 rtl/control_fsm_gen_if.sv | 50 +++++
 rtl/control_fsm_gen.sv | 185 ++++++++++++++++++
 tb/tb_control_fsm_gen.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/control_fsm_gen_if.sv
// control_fsm_gen_if: bundle of instruction, handshake and control signals between the
// control FSM and the datapath / memory it sequences.
//   master modport (control FSM): receives IR, Mem_ready, Zero, Resume; drives all
//     control strobes, addresses, ALU select, State_out, Instr_count, Fault, Illegal.
//   slave modport (datapath side): the mirror image.
interface control_fsm_gen_if #(
    parameter int unsigned IR_W   = 16,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned D_AW   = 8,
    parameter int unsigned ALU_SW = 3,
    parameter int unsigned CNT_W  = 16
);
    logic [IR_W-1:0]   IR;
    logic              Mem_ready;
    logic              Zero;
    logic              Resume;

    logic              PC_clr;
    logic              PC_up;
    logic              PC_ld;
    logic              IR_ld;
    logic              D_wr;
    logic              Mem_req;
    logic              RF_s;
    logic              RF_W_en;
    logic [D_AW-1:0]   D_addr;
    logic [D_AW-1:0]   PC_addr;
    logic [REG_AW-1:0] RF_Ra_addr;
    logic [REG_AW-1:0] RF_Rb_addr;
    logic [REG_AW-1:0] RF_W_addr;
    logic [ALU_SW-1:0] Alu_s0;
    logic [3:0]        State_out;
    logic [CNT_W-1:0]  Instr_count;
    logic              Fault;
    logic              Illegal;

    modport master (
        input  IR, Mem_ready, Zero, Resume,
        output PC_clr, PC_up, PC_ld, IR_ld, D_wr, Mem_req, RF_s, RF_W_en,
        output D_addr, PC_addr, RF_Ra_addr, RF_Rb_addr, RF_W_addr, Alu_s0,
        output State_out, Instr_count, Fault, Illegal
    );

    modport slave (
        output IR, Mem_ready, Zero, Resume,
        input  PC_clr, PC_up, PC_ld, IR_ld, D_wr, Mem_req, RF_s, RF_W_en,
        input  D_addr, PC_addr, RF_Ra_addr, RF_Rb_addr, RF_W_addr, Alu_s0,
        input  State_out, Instr_count, Fault, Illegal
    );
endinterface

// File: rtl/control_fsm_gen.sv
// control_fsm_gen: multi-cycle instruction control FSM (fetch / decode / execute) with a
// memory-wait timeout that traps into a sticky Fault state, and a saturating
// retired-instruction counter.
// Ports:
//   Clk   - clock
//   Reset - asynchronous active-high reset; forces Init, clears counters
//   bus   - control_fsm_gen_if.master: IR/Mem_ready/Zero/Resume in, control strobes,
//           addresses, ALU select, State_out, Instr_count, Fault, Illegal out
module control_fsm_gen #(
    parameter int unsigned IR_W   = 16,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned D_AW   = 8,
    parameter int unsigned ALU_SW = 3,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned MEM_TO = 15
) (
    input logic               Clk,
    input logic               Reset,
    control_fsm_gen_if.master bus
);

    if ((IR_W < OP_W + REG_AW + D_AW) || (IR_W < OP_W + 3 * REG_AW) || (MEM_TO < 1))
    begin : g_param_check
        $error("control_fsm_gen: IR_W too narrow for its fields, or MEM_TO < 1");
    end

    // Wait counter holds 0..MEM_TO-1.
    localparam int unsigned WAIT_W = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;

    typedef enum logic [3:0] {
        StInit   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StNoop   = 4'd3,
        StStore  = 4'd4,
        StLoadA  = 4'd5,
        StLoadB  = 4'd6,
        StAdd    = 4'd7,
        StSub    = 4'd8,
        StHalt   = 4'd9,
        StJmp    = 4'd10,
        StJz     = 4'd11,
        StFault  = 4'd12
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              retire;

    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] ra_field, rb_field, w_field;
    logic [D_AW-1:0]   addr_lo, addr_ld;

    assign opcode   = bus.IR[IR_W-1 -: OP_W];
    assign ra_field = bus.IR[IR_W-OP_W-1 -: REG_AW];
    assign rb_field = bus.IR[IR_W-OP_W-REG_AW-1 -: REG_AW];
    assign w_field  = bus.IR[REG_AW-1:0];
    assign addr_lo  = bus.IR[D_AW-1:0];
    assign addr_ld  = bus.IR[REG_AW+D_AW-1:REG_AW];

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StInit;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        unique case (state_q)
            StInit:   state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OP_W'(0): state_d = StNoop;
                    OP_W'(1): state_d = StStore;
                    OP_W'(2): state_d = StLoadA;
                    OP_W'(3): state_d = StAdd;
                    OP_W'(4): state_d = StSub;
                    OP_W'(5): state_d = StHalt;
                    OP_W'(6): state_d = StJmp;
                    OP_W'(7): state_d = StJz;
                    default:  state_d = StInit;
                endcase
            end
            StStore, StLoadA: begin
                if (bus.Mem_ready) begin
                    state_d = (state_q == StStore) ? StFetch : StLoadB;
                end else if (wait_q == WAIT_W'(MEM_TO - 1)) begin
                    state_d = StFault;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StHalt:   if (bus.Resume) state_d = StFetch;
            StFault:  state_d = StFault;
            StNoop, StLoadB, StAdd, StSub, StJmp, StJz: state_d = StFetch;
            default:  state_d = StInit;
        endcase

        // Retire on leaving an execute state, or on entering Halt.
        retire = ((state_q inside {StNoop, StStore, StLoadB, StAdd, StSub, StJmp, StJz}) &&
                  (state_d != state_q)) ||
                 ((state_q == StDecode) && (state_d == StHalt));
        count_d = (retire && (count_q != '1)) ? count_q + 1'b1 : count_q;
    end

    assign bus.Instr_count = count_q;
    assign bus.State_out   = state_q;

    // Output logic
    always_comb begin
        bus.PC_clr     = 1'b0;
        bus.PC_up      = 1'b0;
        bus.PC_ld      = 1'b0;
        bus.IR_ld      = 1'b0;
        bus.D_wr       = 1'b0;
        bus.Mem_req    = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_en    = 1'b0;
        bus.D_addr     = '0;
        bus.PC_addr    = '0;
        bus.RF_Ra_addr = '0;
        bus.RF_Rb_addr = '0;
        bus.RF_W_addr  = '0;
        bus.Alu_s0     = '0;
        bus.Fault      = 1'b0;
        bus.Illegal    = 1'b0;
        unique case (state_q)
            StInit:   bus.PC_clr = 1'b1;
            StFetch: begin
                bus.IR_ld = 1'b1;
                bus.PC_up = 1'b1;
            end
            // Decode only falls back to Init on an unknown opcode.
            StDecode: bus.Illegal = (state_d == StInit);
            StStore: begin
                bus.Mem_req    = 1'b1;
                bus.D_wr       = 1'b1;
                bus.D_addr     = addr_lo;
                bus.RF_Ra_addr = ra_field;
            end
            StLoadA: begin
                bus.Mem_req   = 1'b1;
                bus.RF_s      = 1'b1;
                bus.D_addr    = addr_ld;
                bus.RF_W_addr = w_field;
            end
            StLoadB: begin
                bus.RF_s      = 1'b1;
                bus.RF_W_en   = 1'b1;
                bus.D_addr    = addr_ld;
                bus.RF_W_addr = w_field;
            end
            StAdd, StSub: begin
                bus.RF_Ra_addr = ra_field;
                bus.RF_Rb_addr = rb_field;
                bus.RF_W_addr  = w_field;
                bus.RF_W_en    = 1'b1;
                bus.Alu_s0     = (state_q == StAdd) ? ALU_SW'(1) : ALU_SW'(2);
            end
            StJmp: begin
                bus.PC_ld   = 1'b1;
                bus.PC_addr = addr_lo;
            end
            StJz: begin
                bus.PC_ld   = bus.Zero;
                bus.PC_addr = addr_lo;
            end
            StFault:  bus.Fault = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_control_fsm_gen.sv
// tb_control_fsm_gen: directed-vector bench for control_fsm_gen. The stimulus process drives
// inputs just after each rising edge and queues the hand-computed expected outputs for that
// cycle; an independent monitor pops and compares on every falling edge.
module tb_control_fsm_gen;

    localparam logic [9:0] C_CLR  = 10'h200;
    localparam logic [9:0] C_UP   = 10'h100;
    localparam logic [9:0] C_LD   = 10'h080;
    localparam logic [9:0] C_IRLD = 10'h040;
    localparam logic [9:0] C_DWR  = 10'h020;
    localparam logic [9:0] C_MREQ = 10'h010;
    localparam logic [9:0] C_RFS  = 10'h008;
    localparam logic [9:0] C_WEN  = 10'h004;
    localparam logic [9:0] C_FLT  = 10'h002;
    localparam logic [9:0] C_ILL  = 10'h001;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [9:0] ctl;
        logic [7:0] daddr;
        logic [7:0] paddr;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] wa;
        logic [2:0] alu;
        int         cnt;   // -1: not checked
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_fsm_gen_if #(
        .IR_W(16), .REG_AW(4), .D_AW(8), .ALU_SW(3), .CNT_W(16)
    ) bus ();

    control_fsm_gen #(
        .IR_W(16), .OP_W(4), .REG_AW(4), .D_AW(8), .ALU_SW(3), .CNT_W(16), .MEM_TO(15)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic exp_t mk(input string name, input logic [3:0] st,
                                input logic [9:0] ctl, input int cnt);
        exp_t e;
        e.name  = name;
        e.st    = st;
        e.ctl   = ctl;
        e.daddr = '0;
        e.paddr = '0;
        e.ra    = '0;
        e.rb    = '0;
        e.wa    = '0;
        e.alu   = '0;
        e.cnt   = cnt;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor
    exp_t       m_e;
    logic [9:0] m_ctl;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            m_e   = q.pop_front();
            m_ctl = {bus.PC_clr, bus.PC_up, bus.PC_ld, bus.IR_ld, bus.D_wr, bus.Mem_req,
                     bus.RF_s, bus.RF_W_en, bus.Fault, bus.Illegal};
            n_tests++;
            if (bus.State_out !== m_e.st || m_ctl !== m_e.ctl || bus.D_addr !== m_e.daddr ||
                bus.PC_addr !== m_e.paddr || bus.RF_Ra_addr !== m_e.ra ||
                bus.RF_Rb_addr !== m_e.rb || bus.RF_W_addr !== m_e.wa ||
                bus.Alu_s0 !== m_e.alu ||
                (m_e.cnt >= 0 && bus.Instr_count !== 16'(m_e.cnt))) begin
                n_fail++;
                $display("FAIL %s: got st=%0d ctl=%b da=%h pa=%h ra=%h rb=%h w=%h alu=%0d cnt=%0d; want st=%0d ctl=%b da=%h pa=%h ra=%h rb=%h w=%h alu=%0d cnt=%0d",
                         m_e.name, bus.State_out, m_ctl, bus.D_addr, bus.PC_addr,
                         bus.RF_Ra_addr, bus.RF_Rb_addr, bus.RF_W_addr, bus.Alu_s0,
                         bus.Instr_count, m_e.st, m_ctl ^ m_ctl ^ m_e.ctl, m_e.daddr,
                         m_e.paddr, m_e.ra, m_e.rb, m_e.wa, m_e.alu, m_e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst           = 1'b1;
        bus.IR        = '0;
        bus.Mem_ready = 1'b0;
        bus.Zero      = 1'b0;
        bus.Resume    = 1'b0;

        // Reset and release
        tick(); q.push_back(mk("reset_init", 4'd0, C_CLR, 0));
        tick(); rst = 1'b0; bus.IR = 16'h3125;
        q.push_back(mk("init_release", 4'd0, C_CLR, 0));

        // Add 3125
        tick(); q.push_back(mk("add_fetch", 4'd1, C_IRLD | C_UP, 0));
        tick(); q.push_back(mk("add_decode", 4'd2, '0, 0));
        tick(); e = mk("add_exec", 4'd7, C_WEN, 0);
        e.ra = 4'd1; e.rb = 4'd2; e.wa = 4'd5; e.alu = 3'd1; q.push_back(e);

        // Load 2A73 with three wait cycles
        tick(); bus.IR = 16'h2A73; bus.Mem_ready = 1'b0;
        q.push_back(mk("lda_fetch", 4'd1, C_IRLD | C_UP, 1));
        tick(); q.push_back(mk("lda_decode", 4'd2, '0, 1));
        for (int i = 0; i < 4; i++) begin
            tick(); bus.Mem_ready = (i == 3);
            e = mk("lda_wait", 4'd5, C_MREQ | C_RFS, 1);
            e.daddr = 8'hA7; e.wa = 4'd3; q.push_back(e);
        end
        tick(); bus.Mem_ready = 1'b0;
        e = mk("ldb", 4'd6, C_RFS | C_WEN, 1); e.daddr = 8'hA7; e.wa = 4'd3; q.push_back(e);

        // Jz 7040, Zero=0 then Zero=1
        tick(); bus.IR = 16'h7040; bus.Zero = 1'b0;
        q.push_back(mk("jz0_fetch", 4'd1, C_IRLD | C_UP, 2));
        tick(); q.push_back(mk("jz0_decode", 4'd2, '0, 2));
        tick(); e = mk("jz_zero0", 4'd11, '0, 2); e.paddr = 8'h40; q.push_back(e);
        tick(); bus.Zero = 1'b1; q.push_back(mk("jz1_fetch", 4'd1, C_IRLD | C_UP, 3));
        tick(); q.push_back(mk("jz1_decode", 4'd2, '0, 3));
        tick(); e = mk("jz_zero1", 4'd11, C_LD, 3); e.paddr = 8'h40; q.push_back(e);

        // Jmp 6012
        tick(); bus.Zero = 1'b0; bus.IR = 16'h6012;
        q.push_back(mk("jmp_fetch", 4'd1, C_IRLD | C_UP, 4));
        tick(); q.push_back(mk("jmp_decode", 4'd2, '0, 4));
        tick(); e = mk("jmp", 4'd10, C_LD, 4); e.paddr = 8'h12; q.push_back(e);

        // Noop with stray Mem_ready, then Store 1B5C completing on its first cycle
        tick(); bus.IR = 16'h0000; bus.Mem_ready = 1'b1;
        q.push_back(mk("noop_fetch", 4'd1, C_IRLD | C_UP, 5));
        tick(); q.push_back(mk("noop_decode", 4'd2, '0, 5));
        tick(); q.push_back(mk("noop", 4'd3, '0, 5));
        tick(); bus.IR = 16'h1B5C; q.push_back(mk("st_fetch", 4'd1, C_IRLD | C_UP, 6));
        tick(); q.push_back(mk("st_decode", 4'd2, '0, 6));
        tick(); e = mk("store_1cyc", 4'd4, C_MREQ | C_DWR, 6);
        e.daddr = 8'h5C; e.ra = 4'hB; q.push_back(e);

        // Illegal F000
        tick(); bus.Mem_ready = 1'b0; bus.IR = 16'hF000;
        q.push_back(mk("ill_fetch", 4'd1, C_IRLD | C_UP, 7));
        tick(); q.push_back(mk("illegal", 4'd2, C_ILL, 7));
        tick(); q.push_back(mk("ill_init", 4'd0, C_CLR, 7));

        // Halt 5000, Resume high outside Halt is ignored
        tick(); bus.IR = 16'h5000; bus.Resume = 1'b1;
        q.push_back(mk("halt_fetch", 4'd1, C_IRLD | C_UP, 7));
        tick(); q.push_back(mk("halt_decode", 4'd2, '0, 7));
        for (int i = 0; i < 10; i++) begin
            tick(); bus.Resume = (i == 9);
            q.push_back(mk("halt_hold", 4'd9, '0, 8));
        end

        // Load 2A73, asynchronous reset mid-wait
        tick(); bus.Resume = 1'b0; bus.IR = 16'h2A73;
        q.push_back(mk("resume_fetch", 4'd1, C_IRLD | C_UP, 8));
        tick(); q.push_back(mk("rl_decode", 4'd2, '0, 8));
        tick(); e = mk("rl_wait", 4'd5, C_MREQ | C_RFS, 8);
        e.daddr = 8'hA7; e.wa = 4'd3; q.push_back(e);
        tick(); #3; rst = 1'b1;
        q.push_back(mk("async_reset", 4'd0, C_CLR, 0));
        tick(); rst = 1'b0; bus.IR = 16'h1342;
        q.push_back(mk("rst_release", 4'd0, C_CLR, 0));

        // Store 1342 that never completes -> Fault after 15 wait cycles
        tick(); q.push_back(mk("to_fetch", 4'd1, C_IRLD | C_UP, 0));
        tick(); q.push_back(mk("to_decode", 4'd2, '0, 0));
        for (int i = 0; i < 15; i++) begin
            tick(); e = mk("store_wait", 4'd4, C_MREQ | C_DWR, 0);
            e.daddr = 8'h42; e.ra = 4'd3; q.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); bus.Mem_ready = 1'b1; bus.Resume = 1'b1;
            q.push_back(mk("fault_sticky", 4'd12, C_FLT, -1));
        end

        // Reset clears Fault; restart with Add 3125
        tick(); bus.Mem_ready = 1'b0; bus.Resume = 1'b0; rst = 1'b1;
        q.push_back(mk("fault_reset", 4'd0, C_CLR, 0));
        tick(); rst = 1'b0; bus.IR = 16'h3125;
        q.push_back(mk("fault_release", 4'd0, C_CLR, 0));
        tick(); q.push_back(mk("re_fetch", 4'd1, C_IRLD | C_UP, 0));
        tick(); q.push_back(mk("re_decode", 4'd2, '0, 0));
        tick(); e = mk("re_add", 4'd7, C_WEN, 0);
        e.ra = 4'd1; e.rb = 4'd2; e.wa = 4'd5; e.alu = 3'd1; q.push_back(e);
        tick(); q.push_back(mk("re_count", 4'd1, C_IRLD | C_UP, 1));

        tick();
        tick();
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
